// File: rtl/ikaopm_timer_bank.sv
// Bank of NUM_CH up-counting interval timers with shared prescaler, sticky IRQ flags
// and a registered active-low combined interrupt.
module ikaopm_timer_bank #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned PRESC_W = 4
) (
    input  logic                      i_EMUCLK,
    input  logic                      i_MRST,
    input  logic                      i_phi1_NCEN_n,
    input  logic                      i_CYCLE_31,
    input  logic [NUM_CH*CNT_W-1:0]   i_RELOAD,
    input  logic [NUM_CH-1:0]         i_RUN,
    input  logic [NUM_CH-1:0]         i_PRESC_SEL,
    input  logic [NUM_CH-1:0]         i_ONESHOT,
    input  logic [NUM_CH-1:0]         i_IRQ_EN,
    input  logic [NUM_CH-1:0]         i_FRST,
    input  logic                      i_TEST_FAST,
    output logic [NUM_CH-1:0]         o_OVFL,
    output logic [NUM_CH-1:0]         o_FLAG,
    output logic [NUM_CH-1:0]         o_ACTIVE,
    output logic                      o_IRQ_n
);

    logic                 tick_r;
    logic [PRESC_W-1:0]   presc;
    logic                 presc_co;
    logic                 presc_co_z;

    logic [NUM_CH-1:0]    rst_r;
    logic [NUM_CH-1:0]    cen;
    logic [NUM_CH-1:0]    co;
    logic [NUM_CH-1:0]    co_z;
    logic [NUM_CH-1:0]    ld_nx;
    logic [NUM_CH-1:0]    sel_tick;
    logic [CNT_W-1:0]     cnt [NUM_CH];

    // Carry detection, next-load terms and per-channel count source
    always_comb begin
        presc_co = tick_r & (&presc);
        co       = '0;
        ld_nx    = '0;
        sel_tick = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            co[c]       = cen[c] & (&cnt[c]);
            ld_nx[c]    = (i_RUN[c] & rst_r[c]) | co_z[c];
            sel_tick[c] = i_PRESC_SEL[c] ? presc_co_z : tick_r;
        end
    end

    // Shared sample-tick prescaler
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            tick_r     <= 1'b0;
            presc      <= '0;
            presc_co_z <= 1'b0;
        end else if (!i_phi1_NCEN_n) begin
            tick_r     <= i_CYCLE_31;
            presc_co_z <= presc_co;
            if (tick_r) presc <= presc + PRESC_W'(1);
        end
    end

    // Channel control pipeline, flags and combined interrupt
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            rst_r    <= '1;
            o_OVFL   <= '0;
            cen      <= '0;
            co_z     <= '0;
            o_ACTIVE <= '0;
            o_FLAG   <= '0;
            o_IRQ_n  <= 1'b1;
        end else if (!i_phi1_NCEN_n) begin
            rst_r   <= ~i_RUN;
            o_OVFL  <= ld_nx;
            co_z    <= co;
            cen     <= o_ACTIVE & ((i_RUN & sel_tick) | {NUM_CH{i_TEST_FAST}});
            o_FLAG  <= ~i_FRST & i_IRQ_EN & (o_FLAG | ld_nx);
            o_IRQ_n <= ~|o_FLAG;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                // rst_r both disarms and, together with RUN, detects the start edge
                if (rst_r[c])
                    o_ACTIVE[c] <= i_RUN[c];
                else if (i_ONESHOT[c] && co_z[c])
                    o_ACTIVE[c] <= 1'b0;
            end
        end
    end

    // Counters: clear beats load beats count
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            for (int unsigned c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end else if (!i_phi1_NCEN_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (rst_r[c])
                    cnt[c] <= '0;
                else if (o_OVFL[c])
                    cnt[c] <= i_RELOAD[c*CNT_W +: CNT_W];
                else if (cen[c])
                    cnt[c] <= cnt[c] + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ikaopm_timer_bank.sv
// Directed bench for ikaopm_timer_bank: per-EC reference model plus hand-computed pins.
module tb_ikaopm_timer_bank;

    localparam int NC   = 2;
    localparam int CW   = 10;
    localparam int PW   = 4;
    localparam int CMOD = 1 << CW;
    localparam int PMOD = 1 << PW;

    logic             clk = 1'b0;
    logic             MRST = 1'b1;
    logic             NCEN_n = 1'b0;
    logic             CYCLE_31 = 1'b0;
    logic [NC*CW-1:0] RELOAD = {10'd1022, 10'd1020};
    logic [NC-1:0]    RUN = '0;
    logic [NC-1:0]    PRESC_SEL = '0;
    logic [NC-1:0]    ONESHOT = '0;
    logic [NC-1:0]    IRQ_EN = '0;
    logic [NC-1:0]    FRST = '0;
    logic             TEST_FAST = 1'b0;
    logic [NC-1:0]    o_OVFL;
    logic [NC-1:0]    o_FLAG;
    logic [NC-1:0]    o_ACTIVE;
    logic             o_IRQ_n;

    int total = 0;
    int bad   = 0;

    ikaopm_timer_bank #(.NUM_CH(NC), .CNT_W(CW), .PRESC_W(PW)) dut (
        .i_EMUCLK(clk), .i_MRST(MRST), .i_phi1_NCEN_n(NCEN_n), .i_CYCLE_31(CYCLE_31),
        .i_RELOAD(RELOAD), .i_RUN(RUN), .i_PRESC_SEL(PRESC_SEL), .i_ONESHOT(ONESHOT),
        .i_IRQ_EN(IRQ_EN), .i_FRST(FRST), .i_TEST_FAST(TEST_FAST),
        .o_OVFL(o_OVFL), .o_FLAG(o_FLAG), .o_ACTIVE(o_ACTIVE), .o_IRQ_n(o_IRQ_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: timer value as a plain integer, pipeline stages as booleans
    int  m_val [NC];
    bit  m_live [NC], m_pulse [NC], m_step [NC], m_wrapped [NC], m_idle [NC], m_flag [NC];
    int  m_div;
    bit  m_tick, m_divdone, m_irqn, mvalid = 1'b0;

    always @(posedge clk) begin
        bit any_flag, div_wrap, start, wrap_now, pulse_nx, live_nx, step_src;
        int val_nx;
        if (MRST) begin
            for (int c = 0; c < NC; c++) begin
                m_val[c] = 0; m_live[c] = 0; m_pulse[c] = 0; m_step[c] = 0;
                m_wrapped[c] = 0; m_idle[c] = 1; m_flag[c] = 0;
            end
            m_div = 0; m_tick = 0; m_divdone = 0; m_irqn = 1; mvalid = 1;
        end else if (!NCEN_n) begin
            any_flag = 0;
            for (int c = 0; c < NC; c++) any_flag = any_flag | m_flag[c];
            div_wrap = m_tick && (m_div == PMOD - 1);
            for (int c = 0; c < NC; c++) begin
                start    = RUN[c] && m_idle[c];
                wrap_now = m_step[c] && (m_val[c] == CMOD - 1);
                pulse_nx = start || m_wrapped[c];
                if (m_idle[c])        val_nx = 0;
                else if (m_pulse[c])  val_nx = int'(RELOAD[c*CW +: CW]);
                else if (m_step[c])   val_nx = (m_val[c] + 1) % CMOD;
                else                  val_nx = m_val[c];
                if (m_idle[c])                       live_nx = RUN[c];
                else if (ONESHOT[c] && m_wrapped[c]) live_nx = 0;
                else                                 live_nx = m_live[c];
                step_src = PRESC_SEL[c] ? m_divdone : m_tick;
                m_step[c]    = m_live[c] && (TEST_FAST || (RUN[c] && step_src));
                m_flag[c]    = !FRST[c] && IRQ_EN[c] && (m_flag[c] || pulse_nx);
                m_wrapped[c] = wrap_now;
                m_pulse[c]   = pulse_nx;
                m_val[c]     = val_nx;
                m_live[c]    = live_nx;
                m_idle[c]    = !RUN[c];
            end
            m_irqn    = !any_flag;
            m_divdone = div_wrap;
            if (m_tick) m_div = (m_div + 1) % PMOD;
            m_tick = CYCLE_31;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            for (int c = 0; c < NC; c++) begin
                check($sformatf("ovfl[%0d]", c),   int'(o_OVFL[c]),   int'(m_pulse[c]));
                check($sformatf("flag[%0d]", c),   int'(o_FLAG[c]),   int'(m_flag[c]));
                check($sformatf("active[%0d]", c), int'(o_ACTIVE[c]), int'(m_live[c]));
            end
            check("irq_n", int'(o_IRQ_n), int'(m_irqn));
        end
    end

    initial begin
        int pulses, first_ov, last_ov, prev_ov;

        // Reset
        step(3);
        check("rst ovfl", int'(o_OVFL), 0);
        check("rst flag", int'(o_FLAG), 0);
        check("rst active", int'(o_ACTIVE), 0);
        check("rst irq_n", int'(o_IRQ_n), 1);
        MRST = 1'b0;
        step(2);

        // Auto-reload, fast count: pulses at EC1, EC7, EC13
        TEST_FAST = 1'b1;
        RUN = 2'b01;
        step(1);
        check("auto ec1 ovfl", int'(o_OVFL[0]), 1);
        check("auto ec1 active", int'(o_ACTIVE[0]), 1);
        step(1);
        check("auto ec2 ovfl", int'(o_OVFL[0]), 0);
        step(5);
        check("auto ec7 ovfl", int'(o_OVFL[0]), 1);
        step(6);
        check("auto ec13 ovfl", int'(o_OVFL[0]), 1);
        for (int i = 0; i < 40; i++) begin
            NCEN_n = (i % 3 == 1);
            step(1);
        end
        NCEN_n = 1'b0;
        RUN = 2'b00;
        step(4);
        check("stop active", int'(o_ACTIVE[0]), 0);

        // One-shot: single overflow after the start pulse, then restart
        ONESHOT = 2'b01;
        RUN = 2'b01;
        step(1);
        check("os ec1 ovfl", int'(o_OVFL[0]), 1);
        step(6);
        check("os ec7 ovfl", int'(o_OVFL[0]), 1);
        check("os ec7 active", int'(o_ACTIVE[0]), 0);
        step(6);
        check("os ec13 ovfl", int'(o_OVFL[0]), 0);
        step(10);
        RUN = 2'b00;
        step(2);
        RUN = 2'b01;
        step(1);
        check("os restart ovfl", int'(o_OVFL[0]), 1);
        check("os restart active", int'(o_ACTIVE[0]), 1);
        step(6);
        check("os restart ec7 ovfl", int'(o_OVFL[0]), 1);
        check("os restart ec7 active", int'(o_ACTIVE[0]), 0);
        RUN = 2'b00;
        ONESHOT = 2'b00;
        step(3);

        // Flags and IRQ, clear colliding with a load
        IRQ_EN = 2'b11;
        RUN = 2'b01;
        step(1);
        check("flag ec1", int'(o_FLAG[0]), 1);
        check("irq ec1", int'(o_IRQ_n), 1);
        step(1);
        check("irq ec2", int'(o_IRQ_n), 0);
        step(4);
        FRST = 2'b01;
        step(1);
        check("frst ec7 ovfl", int'(o_OVFL[0]), 1);
        check("frst ec7 flag", int'(o_FLAG[0]), 0);
        FRST = 2'b00;
        step(1);
        check("frst ec8 irq_n", int'(o_IRQ_n), 1);
        step(5);
        check("flag ec13", int'(o_FLAG[0]), 1);

        // Reset while the clock enable is inactive
        NCEN_n = 1'b1;
        MRST = 1'b1;
        step(1);
        check("gated rst ovfl", int'(o_OVFL), 0);
        check("gated rst flag", int'(o_FLAG), 0);
        check("gated rst active", int'(o_ACTIVE), 0);
        check("gated rst irq_n", int'(o_IRQ_n), 1);
        MRST = 1'b0;
        NCEN_n = 1'b0;

        // RUN still high restarts ch0; drop it while the counter sits at 1021
        step(9);
        RUN = 2'b00;
        step(1);
        check("drop ec10 active", int'(o_ACTIVE[0]), 1);
        step(1);
        check("drop ec11 active", int'(o_ACTIVE[0]), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (o_OVFL[0]) pulses++;
        end
        check("drop no ovfl", pulses, 0);

        // Prescaled channel: one count per 512 EC, reload 1022 -> overflow every 1024 EC
        TEST_FAST = 1'b0;
        IRQ_EN = 2'b10;
        PRESC_SEL = 2'b10;
        RUN = 2'b10;
        pulses = 0; first_ov = -1; last_ov = -1; prev_ov = -1;
        for (int i = 0; i < 2200; i++) begin
            CYCLE_31 = (i % 32 == 31);
            step(1);
            if (o_OVFL[1]) begin
                pulses++;
                if (pulses == 2) first_ov = i + 1;
                prev_ov = last_ov;
                last_ov = i + 1;
            end
        end
        CYCLE_31 = 1'b0;
        check("presc pulses", pulses, 3);
        check("presc first ovfl ec", first_ov, 1028);
        check("presc spacing", last_ov - prev_ov, 1024);

        // Disabling the flag enable clears the sticky flag, IRQ follows one EC later
        check("ien flag before", int'(o_FLAG[1]), 1);
        IRQ_EN = 2'b00;
        step(1);
        check("ien flag after", int'(o_FLAG[1]), 0);
        check("ien irq_n lag", int'(o_IRQ_n), 0);
        step(1);
        check("ien irq_n", int'(o_IRQ_n), 1);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
